// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave -- AXI4-Lite slave bridging ariane_axi req/resp onto a
// single RAM-like port with configurable read latency.
//
// Package ariane_axi (AXI4-Lite channel structs) precedes the module.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   axi_req_i   AXI4-Lite request channels (AW, W, B ready, AR, R ready)
//   axi_resp_o  AXI4-Lite response channels
//   en_o        memory access strobe, one cycle per access
//   we_o        write qualifier for en_o
//   addr_o      byte offset inside the window (addr - ADDR_BASE)
//   be_o        write byte enables
//   data_o      write data
//   data_i      read data, valid READ_LATENCY cycles after a read en_o

package ariane_axi;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 10;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
    } addr_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        addr_chan_t aw;
        logic       aw_valid;
        w_chan_t    w;
        logic       w_valid;
        logic       b_ready;
        addr_chan_t ar;
        logic       ar_valid;
        logic       r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_lite_mem_slave #(
    parameter int unsigned                AXI_ADDR_WIDTH = 64,
    parameter int unsigned                AXI_DATA_WIDTH = 64,
    parameter int unsigned                AXI_ID_WIDTH   = 10,
    parameter int unsigned                READ_LATENCY   = 1,
    parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_BASE      = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_SIZE      = AXI_ADDR_WIDTH'(4096)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  ariane_axi::req_t              axi_req_i,
    output ariane_axi::resp_t             axi_resp_o,
    output logic                          en_o,
    output logic                          we_o,
    output logic [AXI_ADDR_WIDTH-1:0]     addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]   be_o,
    output logic [AXI_DATA_WIDTH-1:0]     data_o,
    input  logic [AXI_DATA_WIDTH-1:0]     data_i
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_WAIT  = 2'd2;
    localparam logic [1:0] R_RESP  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] WAIT_LAST = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

    typedef logic [ariane_axi::IdWidth-1:0]   axi_id_t;
    typedef logic [ariane_axi::DataWidth-1:0] axi_data_t;

    function automatic logic addr_hit(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = a - ADDR_BASE;
        return (a >= ADDR_BASE) && (off < ADDR_SIZE);
    endfunction

    // write path state
    logic                      aw_held_q, w_held_q, b_valid_q;
    logic [1:0]                b_resp_q;
    logic [AXI_ADDR_WIDTH-1:0] waddr_q;
    logic [AXI_ID_WIDTH-1:0]   wid_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]     wstrb_q;

    // read path state
    logic [1:0]                r_state_q;
    logic [AXI_ADDR_WIDTH-1:0] raddr_q;
    logic [AXI_ID_WIDTH-1:0]   rid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                r_resp_q;
    logic [2:0]                wait_cnt_q;

    // 1: read won the last conflict. Resets to 1 so the first conflict goes to write.
    logic                      last_gnt_read_q;

    logic aw_ready, w_ready, ar_ready;
    logic aw_hs, w_hs, ar_hs;
    logic w_pend, w_hit, r_hit, r_issue, conflict;
    logic w_gnt, r_gnt, w_done;

    always_comb begin
        aw_ready = !aw_held_q && !b_valid_q;
        w_ready  = !w_held_q && !b_valid_q;
        ar_ready = (r_state_q == R_IDLE);
        aw_hs    = axi_req_i.aw_valid && aw_ready;
        w_hs     = axi_req_i.w_valid && w_ready;
        ar_hs    = axi_req_i.ar_valid && ar_ready;

        w_pend   = aw_held_q && w_held_q && !b_valid_q;
        w_hit    = addr_hit(waddr_q);
        r_hit    = addr_hit(raddr_q);
        r_issue  = (r_state_q == R_ISSUE);
        // Only two hits compete for the port; misses complete without it.
        conflict = w_pend && w_hit && r_issue && r_hit;
        w_gnt    = w_pend && w_hit && (!conflict || last_gnt_read_q);
        r_gnt    = r_issue && r_hit && (!conflict || !last_gnt_read_q);
        w_done   = w_pend && (w_gnt || !w_hit);
    end

    always_comb begin
        en_o   = w_gnt || r_gnt;
        we_o   = w_gnt;
        addr_o = '0;
        be_o   = '0;
        data_o = '0;
        if (w_gnt) begin
            addr_o = waddr_q - ADDR_BASE;
            be_o   = wstrb_q;
            data_o = wdata_q;
        end else if (r_gnt) begin
            addr_o = raddr_q - ADDR_BASE;
        end
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = axi_id_t'(wid_q);
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.r_valid  = (r_state_q == R_RESP);
        axi_resp_o.r.id     = axi_id_t'(rid_q);
        axi_resp_o.r.data   = axi_data_t'(rdata_q);
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r.last   = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_resp_q  <= '0;
            waddr_q   <= '0;
            wid_q     <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                waddr_q   <= axi_req_i.aw.addr[AXI_ADDR_WIDTH-1:0];
                wid_q     <= axi_req_i.aw.id[AXI_ID_WIDTH-1:0];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= axi_req_i.w.data[AXI_DATA_WIDTH-1:0];
                wstrb_q  <= axi_req_i.w.strb[STRB_WIDTH-1:0];
            end
            if (w_done) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= w_hit ? RESP_OKAY : RESP_DECERR;
            end
            if (b_valid_q && axi_req_i.b_ready) begin
                b_valid_q <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q       <= R_IDLE;
            raddr_q         <= '0;
            rid_q           <= '0;
            rdata_q         <= '0;
            r_resp_q        <= '0;
            wait_cnt_q      <= '0;
            last_gnt_read_q <= 1'b1;
        end else begin
            if (conflict) last_gnt_read_q <= !last_gnt_read_q;
            case (r_state_q)
                R_IDLE: if (ar_hs) begin
                    raddr_q   <= axi_req_i.ar.addr[AXI_ADDR_WIDTH-1:0];
                    rid_q     <= axi_req_i.ar.id[AXI_ID_WIDTH-1:0];
                    r_state_q <= R_ISSUE;
                end
                R_ISSUE: begin
                    if (!r_hit) begin
                        rdata_q   <= '0;
                        r_resp_q  <= RESP_DECERR;
                        r_state_q <= R_RESP;
                    end else if (r_gnt) begin
                        r_resp_q <= RESP_OKAY;
                        if (READ_LATENCY == 0) begin
                            rdata_q   <= data_i;
                            r_state_q <= R_RESP;
                        end else begin
                            wait_cnt_q <= '0;
                            r_state_q  <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        rdata_q   <= data_i;
                        r_state_q <= R_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end
                default: if (axi_req_i.r_ready) r_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave -- directed bench for axi_lite_mem_slave with
// READ_LATENCY=2, window 0x1000..0x1FFF.
module tb_axi_lite_mem_slave;
    localparam logic [63:0] BASE = 64'h1000;
    localparam logic [63:0] SIZE = 64'h1000;

    typedef struct {
        int          c;
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } en_rec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    ariane_axi::req_t  req;
    ariane_axi::resp_t resp;
    logic              en, we;
    logic [63:0]       addr, wdat, rdat;
    logic [7:0]        be;

    int      cyc = 0;
    int      n_cmp = 0;
    int      n_err = 0;
    en_rec_t en_log[$];

    axi_lite_mem_slave #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
        .READ_LATENCY(2), .ADDR_BASE(BASE), .ADDR_SIZE(SIZE)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .axi_req_i(req), .axi_resp_o(resp),
        .en_o(en), .we_o(we), .addr_o(addr), .be_o(be), .data_o(wdat), .data_i(rdat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (en === 1'b1) en_log.push_back('{cyc, we, addr, be, wdat});

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_aw_w(input logic do_aw, input logic do_w, input logic [63:0] a,
                             input logic [9:0] id, input logic [63:0] d,
                             input logic [7:0] s, output int hs);
        logic aw_done, w_done, any;
        aw_done = !do_aw; w_done = !do_w; hs = -1;
        req.aw.addr = a; req.aw.id = id; req.w.data = d; req.w.strb = s;
        req.aw_valid = do_aw; req.w_valid = do_w;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any = 1'b0;
            if (req.aw_valid && resp.aw_ready) begin aw_done = 1'b1; any = 1'b1; end
            if (req.w_valid && resp.w_ready) begin w_done = 1'b1; any = 1'b1; end
            if (any) hs = cyc;
            tick();
            if (aw_done) req.aw_valid = 1'b0;
            if (w_done) req.w_valid = 1'b0;
            if (aw_done && w_done) return;
        end
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        n_cmp++; n_err++; $display("FAIL aw_w_timeout: no handshake in 20 cycles");
    endtask

    task automatic send_ar(input logic [63:0] a, input logic [9:0] id, output int hs);
        hs = -1; req.ar.addr = a; req.ar.id = id; req.ar_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp.ar_ready) begin hs = cyc; tick(); req.ar_valid = 1'b0; return; end
            tick();
        end
        req.ar_valid = 1'b0;
        n_cmp++; n_err++; $display("FAIL ar_timeout: no handshake in 20 cycles");
    endtask

    task automatic wait_b(output int c, output logic [9:0] id, output logic [1:0] rs);
        c = -1; id = '0; rs = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp.b_valid) begin c = cyc; id = resp.b.id; rs = resp.b.resp; tick(); return; end
            tick();
        end
        n_cmp++; n_err++; $display("FAIL b_timeout: b_valid absent for 20 cycles");
    endtask

    task automatic wait_r(output int c, output logic [63:0] d, output logic [9:0] id,
                          output logic [1:0] rs);
        c = -1; d = '0; id = '0; rs = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp.r_valid) begin
                c = cyc; d = resp.r.data; id = resp.r.id; rs = resp.r.resp; tick(); return;
            end
            tick();
        end
        n_cmp++; n_err++; $display("FAIL r_timeout: r_valid absent for 20 cycles");
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [6:0] ctl;
        ctl = {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid, en, we};
        n_cmp++;
        if (ctl !== 7'b1110000) begin
            n_err++; $display("FAIL %s_ctl: got %b want 1110000", tag, ctl);
        end
        n_cmp++;
        if ({addr, be, wdat} !== '0) begin
            n_err++; $display("FAIL %s_port: got %h/%h/%h want 0", tag, addr, be, wdat);
        end
        n_cmp++;
        if ({resp.r.data, resp.r.id, resp.b.id, resp.r.resp, resp.b.resp, resp.r.last} !== 89'd1) begin
            n_err++;
            $display("FAIL %s_resp: got rdata=%h rid=%h bid=%h rresp=%b bresp=%b last=%b want 0s,last=1",
                     tag, resp.r.data, resp.r.id, resp.b.id, resp.r.resp, resp.b.resp, resp.r.last);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; rdat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_write_w_first();
        int hw, ta, cb; logic [9:0] bid; logic [1:0] brs;
        en_log.delete();
        send_aw_w(1'b0, 1'b1, '0, '0, 64'h1122334455667788, 8'h0F, hw);
        tick(); tick();
        send_aw_w(1'b1, 1'b0, BASE + 64'h10, 10'd5, '0, '0, ta);
        n_cmp++;
        if (ta !== hw + 3) begin n_err++; $display("FAIL wfirst_aw_cycle: got %0d want %0d", ta, hw + 3); end
        req.b_ready = 1'b1;
        wait_b(cb, bid, brs);
        req.b_ready = 1'b0;
        n_cmp++;
        if (cb !== ta + 2) begin n_err++; $display("FAIL wfirst_b_cycle: got %0d want %0d", cb, ta + 2); end
        n_cmp++;
        if ({bid, brs} !== {10'd5, 2'b00}) begin
            n_err++; $display("FAIL wfirst_b_fields: got id=%0d resp=%b want 5/00", bid, brs);
        end
        n_cmp++;
        if (en_log.size() !== 1) begin
            n_err++; $display("FAIL wfirst_en_count: got %0d want 1", en_log.size());
        end else if (en_log[0].c !== ta + 1 || en_log[0].we !== 1'b1 || en_log[0].addr !== 64'h10 ||
                     en_log[0].be !== 8'h0F || en_log[0].data !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL wfirst_en: got c=%0d we=%b a=%h be=%h d=%h want c=%0d we=1 a=10 be=0f d=1122334455667788",
                     en_log[0].c, en_log[0].we, en_log[0].addr, en_log[0].be, en_log[0].data, ta + 1);
        end
    endtask

    task automatic test_read_latency();
        int hs, first;
        en_log.delete();
        send_ar(BASE + 64'h8, 10'd3, hs);
        first = -1;
        for (int i = 0; i < 12 && first < 0; i++) begin
            rdat = (cyc == hs + 3) ? 64'hA5A5 : 64'hDEAD_0000 + 64'(i);
            @(negedge clk);
            if (resp.r_valid) first = cyc; else tick();
        end
        n_cmp++;
        if (first !== hs + 4) begin n_err++; $display("FAIL rlat_rvalid_cycle: got %0d want %0d", first, hs + 4); end
        if (first < 0) return;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (!(resp.r_valid === 1'b1 && resp.r.data === 64'hA5A5 && resp.r.resp === 2'b00 &&
                  resp.ar_ready === 1'b0)) begin
                n_err++;
                $display("FAIL rlat_hold%0d: got rv=%b data=%h resp=%b arr=%b want 1/a5a5/00/0",
                         i, resp.r_valid, resp.r.data, resp.r.resp, resp.ar_ready);
            end
            tick(); rdat = 64'hBEEF_0000 + 64'(i);
        end
        req.r_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({resp.r_valid, resp.r.id, resp.r.last} !== {1'b1, 10'd3, 1'b1}) begin
            n_err++; $display("FAIL rlat_resp: got rv=%b id=%0d last=%b want 1/3/1",
                              resp.r_valid, resp.r.id, resp.r.last);
        end
        tick(); req.r_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({resp.ar_ready, resp.r_valid} !== 2'b10) begin
            n_err++; $display("FAIL rlat_after: got arr=%b rv=%b want 1/0", resp.ar_ready, resp.r_valid);
        end
        tick();
        n_cmp++;
        if (en_log.size() !== 1 || en_log[0].c !== hs + 1 || en_log[0].we !== 1'b0 ||
            en_log[0].addr !== 64'h8) begin
            n_err++; $display("FAIL rlat_en: got %0d pulses want one read at cycle %0d addr 8",
                              en_log.size(), hs + 1);
        end
    endtask

    task automatic test_miss();
        int t, c; logic [9:0] id; logic [1:0] rs; logic [63:0] d;
        logic [63:0] raddrs [2];
        raddrs[0] = BASE + SIZE; raddrs[1] = BASE - 64'h8;
        en_log.delete();
        send_aw_w(1'b1, 1'b1, BASE + SIZE, 10'd9, 64'hFFFF, 8'hFF, t);
        req.b_ready = 1'b1;
        wait_b(c, id, rs);
        req.b_ready = 1'b0;
        n_cmp++;
        if ({c == t + 2, id, rs} !== {1'b1, 10'd9, 2'b11}) begin
            n_err++; $display("FAIL miss_b: got c=%0d id=%0d resp=%b want c=%0d id=9 resp=11", c, id, rs, t + 2);
        end
        req.r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send_ar(raddrs[i], 10'(i + 20), t);
            wait_r(c, d, id, rs);
            n_cmp++;
            if ({c == t + 2, d, id, rs} !== {1'b1, 64'h0, 10'(i + 20), 2'b11}) begin
                n_err++; $display("FAIL miss_r%0d: got c=%0d data=%h id=%0d resp=%b want c=%0d data=0 id=%0d resp=11",
                                  i, c, d, id, rs, t + 2, i + 20);
            end
        end
        req.r_ready = 1'b0;
        n_cmp++;
        if (en_log.size() !== 0) begin n_err++; $display("FAIL miss_en: got %0d pulses want 0", en_log.size()); end
    endtask

    task automatic test_conflict();
        int t, cb, cr; logic [9:0] id; logic [1:0] rs; logic [63:0] d;
        req.b_ready = 1'b1; req.r_ready = 1'b1; rdat = 64'h5555;
        for (int k = 0; k < 2; k++) begin
            en_log.delete();
            req.aw.addr = BASE + 64'h40; req.aw.id = 10'd1; req.w.data = 64'hCAFE; req.w.strb = 8'hFF;
            req.ar.addr = BASE + 64'h48; req.ar.id = 10'd2;
            req.aw_valid = 1'b1; req.w_valid = 1'b1; req.ar_valid = 1'b1;
            @(negedge clk);
            t = cyc;
            n_cmp++;
            if ({resp.aw_ready, resp.w_ready, resp.ar_ready} !== 3'b111) begin
                n_err++; $display("FAIL conf%0d_ready: got %b want 111", k,
                                  {resp.aw_ready, resp.w_ready, resp.ar_ready});
            end
            tick();
            req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
            wait_b(cb, id, rs);
            wait_r(cr, d, id, rs);
            n_cmp++;
            if (en_log.size() !== 2 || en_log[0].c !== t + 1 || en_log[1].c !== t + 2 ||
                en_log[0].we !== (k == 0) || en_log[1].we !== (k != 0)) begin
                n_err++; $display("FAIL conf%0d_order: got %0d pulses, first we=%b want 2 pulses, first we=%b",
                                  k, en_log.size(), (en_log.size() > 0) ? en_log[0].we : 1'bx, k == 0);
            end
            n_cmp++;
            if (cb !== t + ((k == 0) ? 2 : 3) || cr !== t + ((k == 0) ? 5 : 4) || d !== 64'h5555) begin
                n_err++; $display("FAIL conf%0d_resp: got b@%0d r@%0d data=%h want b@%0d r@%0d data=5555",
                                  k, cb, cr, d, t + ((k == 0) ? 2 : 3), t + ((k == 0) ? 5 : 4));
            end
        end
        req.b_ready = 1'b0; req.r_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t, c; logic [9:0] id; logic [1:0] rs;
        en_log.delete();
        req.b_ready = 1'b0;
        send_aw_w(1'b1, 1'b1, BASE + 64'h100, 10'd11, 64'h1111, 8'h03, t);
        req.aw.addr = BASE + 64'h200; req.aw.id = 10'd12; req.w.data = 64'h2222; req.w.strb = 8'hC0;
        req.aw_valid = 1'b1; req.w_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) req.b_ready = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({resp.aw_ready, resp.w_ready, resp.b_valid} !== {2'b00, i != 0}) begin
                n_err++; $display("FAIL b2b_stall%0d: got awr=%b wr=%b bv=%b want 0/0/%b",
                                  i, resp.aw_ready, resp.w_ready, resp.b_valid, i != 0);
            end
            tick();
        end
        req.b_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({resp.aw_ready, resp.w_ready, resp.b_valid} !== 3'b110) begin
            n_err++; $display("FAIL b2b_accept: got awr=%b wr=%b bv=%b want 1/1/0",
                              resp.aw_ready, resp.w_ready, resp.b_valid);
        end
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0; req.b_ready = 1'b1;
        wait_b(c, id, rs);
        req.b_ready = 1'b0;
        n_cmp++;
        if ({c == t + 9, id, rs} !== {1'b1, 10'd12, 2'b00}) begin
            n_err++; $display("FAIL b2b_b2: got c=%0d id=%0d resp=%b want c=%0d id=12 resp=00", c, id, rs, t + 9);
        end
        n_cmp++;
        if (en_log.size() !== 2 || en_log[0].c !== t + 1 || en_log[0].addr !== 64'h100 ||
            en_log[1].c !== t + 8 || en_log[1].addr !== 64'h200 || en_log[1].be !== 8'hC0 ||
            en_log[1].data !== 64'h2222) begin
            n_err++; $display("FAIL b2b_en: got %0d pulses want writes at %0d (0x100) and %0d (0x200)",
                              en_log.size(), t + 1, t + 8);
        end
    endtask

    task automatic test_reset_mid();
        int hs, c; logic [9:0] id; logic [1:0] rs; logic [63:0] d; logic seen;
        send_ar(BASE + 64'h20, 10'd7, hs);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick(); rst_n = 1'b1; en_log.delete();
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp.r_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if ({seen, en_log.size() == 0} !== 2'b01) begin
            n_err++; $display("FAIL midrst_quiet: got rvalid_seen=%b en_pulses=%0d want 0/0", seen, en_log.size());
        end
        rdat = 64'h77; req.r_ready = 1'b1;
        send_ar(BASE + 64'h28, 10'd8, hs);
        wait_r(c, d, id, rs);
        req.r_ready = 1'b0;
        n_cmp++;
        if ({c == hs + 4, d, id, rs} !== {1'b1, 64'h77, 10'd8, 2'b00}) begin
            n_err++; $display("FAIL midrst_read: got c=%0d data=%h id=%0d resp=%b want c=%0d data=77 id=8 resp=00",
                              c, d, id, rs, hs + 4);
        end
        n_cmp++;
        if (en_log.size() !== 1 || en_log[0].c !== hs + 1 || en_log[0].addr !== 64'h28) begin
            n_err++; $display("FAIL midrst_en: got %0d pulses want one at cycle %0d addr 28", en_log.size(), hs + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_w_first();
        test_read_latency();
        test_miss();
        test_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

Parametrised AXI4-Lite slave that bridges an `ariane_axi` request/response pair onto a single RAM-like port. The slave has independent write and read paths with separate ID registers, and accepts AW and W in any order. It supports a configurable memory read latency, holds read data in a register so it stays stable under backpressure, and returns DECERR for addresses outside its window. It sits between the interconnect and on-chip memories or register files whose read data arrives more than one cycle after the request.

## Interface
- AXI_ADDR_WIDTH, 64: address width; also the width of the memory offset.
- AXI_DATA_WIDTH, 64: data width; strobe width is AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 10: transaction ID width.
- READ_LATENCY, 1: cycles from the `en_o` read cycle to valid `data_i`. Legal range 0..4; 0 means combinational.
- ADDR_BASE, 0: window base address.
- ADDR_SIZE, 4096: window size in bytes. Must be greater than 0.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- axi_req_i  in  ariane_axi::req_t  AXI4-Lite request channels.
- axi_resp_o  out  ariane_axi::resp_t  AXI4-Lite response channels.
- en_o  out  1  memory access strobe, one cycle per access.
- we_o  out  1  write qualifier for `en_o`.
- addr_o  out  AXI_ADDR_WIDTH  byte offset, equal to addr − ADDR_BASE.
- be_o  out  AXI_DATA_WIDTH/8  write byte enables.
- data_o  out  AXI_DATA_WIDTH  write data.
- data_i  in  AXI_DATA_WIDTH  read data, valid READ_LATENCY cycles after the read `en_o`.

## Operation
- Decode: an address hits when addr ≥ ADDR_BASE and (addr − ADDR_BASE) < ADDR_SIZE. The subtraction is computed in AXI_ADDR_WIDTH bits. A miss never drives `en_o` and responds 2'b11 (DECERR). A hit responds 2'b00.
- Write path:
  - State consists of flags aw_held and w_held, plus registers waddr, wid, wdata and wstrb.
  - aw_ready = !aw_held && !b_valid. w_ready = !w_held && !b_valid.
  - When both flags are set, the write is pending.
  - On grant, a hit drives en_o=we_o=1 for one cycle with the held addr/data/strb. A miss drives no access.
  - b_valid rises the next cycle with b.id = wid and b.resp per decode. b_valid holds until b_ready.
  - On the b handshake, both flags clear.
- Read path, states R_IDLE, R_ISSUE, R_WAIT, R_RESP:
  - R_IDLE: ar_ready=1. On the ar handshake, latch raddr and rid, then go to R_ISSUE.
  - R_ISSUE: on a hit with grant, drive en_o=1, we_o=0. Go to R_WAIT, or to R_RESP when READ_LATENCY=0 (capturing data_i in the same cycle). A miss goes directly to R_RESP with rdata_q=0 and resp DECERR.
  - R_WAIT: count READ_LATENCY cycles, then capture data_i into rdata_q and go to R_RESP.
  - R_RESP: r_valid=1, r.data=rdata_q, r.id=rid, r.last=1. Return to R_IDLE on r_ready.
- Arbitration for the single port:
  - Arbitration applies only in a cycle where a write is pending and the read is in R_ISSUE with a hit.
  - Round-robin: the side not granted last time wins.
  - After reset, write has priority.
  - The losing side waits; it is granted the next cycle.
  - Writes may issue while a read is in R_WAIT, because the memory is pipelined.
- When en_o=0, addr_o, be_o and data_o are '0.

## Timing
- Reset values:
  - aw_ready=w_ready=ar_ready=1.
  - b_valid=r_valid=0.
  - en_o=we_o=0; addr_o/be_o/data_o=0.
  - r.data, r.id, b.id, r.resp and b.resp are all 0.
  - r.last=1.
- Write: with the later of the AW/W handshakes at cycle T, issue is at T+1 at the earliest and b_valid at T+2 at the earliest. This also holds for a miss.
- Read hit: with the ar handshake at T, en_o is at T+1 at the earliest and r_valid at T+2+READ_LATENCY. A read miss gives r_valid at T+2.
- AW and W handshakes in the same cycle are legal. W may precede AW by any number of cycles.
- Only one write and one read are outstanding at a time. The next AW/W is accepted from the cycle after the b handshake. The next AR is accepted from the cycle after the r handshake.
- r.data and r.resp stay constant while r_valid=1 and r_ready=0, even though data_i changes.
- Reset mid-operation: all held transactions and counters are discarded. No `en_o` is driven after reset is deasserted until a new handshake occurs.

## Test plan
- W (data 0x1122334455667788, strb 0x0F) 3 cycles before AW (addr ADDR_BASE+0x10, id 5) -> a single en_o/we_o pulse with addr_o=0x10 and be_o=0x0F, then b_valid with b.id=5 and resp 0, 2 cycles after the AW handshake.
- READ_LATENCY=2, AR at ADDR_BASE+0x8 at T, data_i=0xA5A5 at T+3 then changing, r_ready low for 5 cycles -> en_o only at T+1, r_valid at T+4, r.data=0xA5A5 held stable, ar_ready low until after the r handshake.
- Read and write at ADDR_BASE+ADDR_SIZE -> no en_o, r.resp=b.resp=2'b11, r.data=0.
- Write pending and read in R_ISSUE simultaneously, twice in succession -> first conflict grants write then read the next cycle, second conflict grants read first.
- b_ready held low 4 cycles with a new AW/W presented -> aw_ready=w_ready=0 until the cycle after b_ready; the second write then completes normally.
- Assert rst_ni during R_WAIT -> r_valid never rises, all outputs at reset values, and the next read completes with the correct latency.
